sr_ff_bank: RTL and testbench
=============================

# sr_ff_bank

Parametrised bank of clocked SR flip-flops sharing one clock, with a selectable resolution mode for the S=R=1 case and a conflict monitor. It replaces the single ungated NAND SR latch in control and status paths that need many synchronous set/clear bits: sticky flags, request and grant bits, per-channel enable bits. Every state change is synchronous to `clk` and has a defined result. The forbidden-input case of the plain latch does not exist in this block.

## Interface
Parameters:
- `WIDTH`, default 8: number of independent SR channels (1..64).
- `CNT_W`, default 8: width of the conflict counter (2..16).

Ports:
- `clk`, input, 1: single clock, rising-edge active.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `en`, input, 1: global sample enable. When 0, all channels hold.
- `s`, input, WIDTH: per-channel set, active-high.
- `r`, input, WIDTH: per-channel reset, active-high.
- `mode`, input, 2: conflict resolution for channels with s=r=1.
  - 00: hold
  - 01: set-dominant
  - 10: reset-dominant
  - 11: toggle (JK behaviour)
- `clr_cnt`, input, 1: synchronous clear of `conflict_cnt`.
- `q`, output, WIDTH: channel state.
- `qb`, output, WIDTH: always the bitwise complement of `q`, including during reset.
- `conflict`, output, 1: registered flag. High for one cycle after any edge at which some channel had s=r=1 while en=1.
- `conflict_cnt`, output, CNT_W: saturating count of conflict cycles.

## Operation
- Each channel i evaluates independently at every rising edge of `clk` while en=1:
  - s=0, r=0: hold.
  - s=1, r=0: q[i] becomes 1.
  - s=0, r=1: q[i] becomes 0.
  - s=1, r=1: resolved by `mode`:
    - 00: q[i] holds.
    - 01: q[i] becomes 1.
    - 10: q[i] becomes 0.
    - 11: q[i] becomes ~q[i].
- en=0: every channel holds. `conflict` is 0 at the next edge. The counter does not increment, but `clr_cnt` still applies.
- `mode` is sampled at each edge and applies to all channels. Changing it between cycles is legal and takes effect at the next edge.
- `conflict` is registered: conflict_next = en & |(s & r).
- `conflict_cnt` updates at each edge:
  - `clr_cnt`=1: becomes 0. Clear wins over a simultaneous increment.
  - `clr_cnt`=0 and conflict_next=1: increments by 1, saturating at 2^CNT_W-1. It counts cycles, not channels: several conflicting channels in one cycle add exactly 1.
  - Otherwise: holds.
- `qb` is derived combinationally as ~q. q and qb are never equal.

## Timing
- Latency: inputs sampled at edge N appear on `q`, `qb`, `conflict` and `conflict_cnt` immediately after edge N. No combinational path from `s`, `r`, `en` or `mode` to any output.
- Reset values:
  - q = 0
  - qb = all ones
  - conflict = 0
  - conflict_cnt = 0
- Reset asserts asynchronously. Outputs reach their reset values without a clock edge.
- Reset deassertion is sampled. The first edge with rst_n=1 performs a normal evaluation.
- Reset mid-operation: any pending conflict, toggle or count is discarded. Nothing is held over.
- Counter at saturation plus a further conflict: stays at max. `conflict` still pulses.
- Toggle mode with s=r=1 held for k cycles: q[i] alternates every cycle. After an even k it equals its start value.

## Configuration
- Macro `SR_FF_BANK_CONFLICT_CNT_EN`.
- Defined: `conflict_cnt` and `clr_cnt` behave as specified above.
- Undefined:
  - The counter register is not built.
  - `conflict_cnt` is tied to 0.
  - `clr_cnt` is ignored.
  - `conflict` and all channel behaviour are unchanged.

## Test plan
All scenarios use WIDTH=8 and CNT_W=4.
- Reset: drive rst_n=0 mid-cycle, with no clock edge needed, from q=8'hA5 → q=8'h00, qb=8'hFF, conflict=0, cnt=0.
- Basic set and reset, en=1:
  - s=8'h0F, r=0 → q=8'h0F.
  - Then s=0, r=8'h03 → q=8'h0C.
  - Then s=r=0 for 3 cycles → q stays 8'h0C.
- Conflict modes, with q=8'h0C and s=r=8'h05 for one cycle:
  - mode 00 → 8'h0C.
  - mode 01 → 8'h0D.
  - mode 10 → 8'h08.
  - mode 11 → 8'h09.
  - In every case conflict=1 for one cycle.
- Toggle hold: mode 11, s=r=8'h01 for 4 cycles from q=0 → q[0] goes 1,0,1,0. Cnt goes 1,2,3,4.
- Enable gating: en=0, s=8'hFF, r=8'hFF → q unchanged, conflict=0, cnt unchanged.
- Counter:
  - 20 consecutive conflict cycles → cnt saturates at 15.
  - clr_cnt=1 together with a conflict → cnt=0 and conflict=1.
  - With the macro undefined → cnt is 0 throughout.

Source files
------------

// File: rtl/sr_ff_bank.sv
// sr_ff_bank: bank of clocked SR flip-flops with selectable S=R=1 resolution and conflict monitor.
// Optional saturating conflict counter is built when SR_FF_BANK_CONFLICT_CNT_EN is defined.
module sr_ff_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [1:0]       mode,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] q_next;
    logic             conflict_next;

    // next state per channel: set, reset, hold, or the mode-selected result where s=r=1
    always_comb begin
        res           = (mode == 2'b00) ? q_r : (mode == 2'b01) ? '1 : (mode == 2'b10) ? '0 : ~q_r;
        q_next        = (s & ~r) | (~s & ~r & q_r) | (s & r & res);
        conflict_next = en & |(s & r);
    end

    // channel state and one-cycle conflict flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r      <= '0;
            conflict <= 1'b0;
        end else begin
            if (en) q_r <= q_next;
            conflict <= conflict_next;
        end
    end

    assign q  = q_r;
    assign qb = ~q_r;

`ifdef SR_FF_BANK_CONFLICT_CNT_EN
    logic [CNT_W-1:0] cnt_r;

    // saturating count of conflict cycles; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_r <= '0;
        else if (clr_cnt) cnt_r <= '0;
        else if (conflict_next && cnt_r != '1) cnt_r <= cnt_r + CNT_W'(1);
    end

    assign conflict_cnt = cnt_r;
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign conflict_cnt   = '0;
`endif
endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: randomized and directed checks of sr_ff_bank against a behavioural model.
module tb_sr_ff_bank;
    localparam int W = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          en = 0;
    logic [W-1:0]  s = '0;
    logic [W-1:0]  r = '0;
    logic [1:0]    mode = 2'b00;
    logic          clr_cnt = 0;
    logic [W-1:0]  q;
    logic [W-1:0]  qb;
    logic          conflict;
    logic [CW-1:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q_m = '0;
    logic         conf_m = 0;
    int           cnt_m = 0;

    sr_ff_bank #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .mode(mode),
        .clr_cnt(clr_cnt), .q(q), .qb(qb), .conflict(conflict), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic e, input logic [W-1:0] sv, input logic [W-1:0] rv,
                              input logic [1:0] m, input logic c);
        int hits = 0;
        if (e) begin
            for (int i = 0; i < W; i++) begin
                if (sv[i] && rv[i]) begin
                    hits++;
                    if (m == 2'd1) q_m[i] = 1'b1;
                    else if (m == 2'd2) q_m[i] = 1'b0;
                    else if (m == 2'd3) q_m[i] = !q_m[i];
                end else if (sv[i]) q_m[i] = 1'b1;
                else if (rv[i]) q_m[i] = 1'b0;
            end
        end
        conf_m = hits > 0;
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
        if (c) cnt_m = 0;
        else if (conf_m && cnt_m < CMAX) cnt_m = cnt_m + 1;
`else
        cnt_m = 0;
`endif
    endtask

    task automatic model_reset();
        q_m = '0;
        conf_m = 0;
        cnt_m = 0;
    endtask

    task automatic cycle(input logic e, input logic [W-1:0] sv, input logic [W-1:0] rv,
                         input logic [1:0] m, input logic c);
        @(negedge clk);
        en = e; s = sv; r = rv; mode = m; clr_cnt = c;
        @(posedge clk);
        model_edge(e, sv, rv, m, c);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (q !== '0) begin errors++; $display("FAIL reset_q: got %h exp 00", q); end
        checks++; if (qb !== '1) begin errors++; $display("FAIL reset_qb: got %h exp ff", qb); end
        checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b exp 0", conflict); end
        checks++; if (conflict_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", conflict_cnt); end
        @(negedge clk) rst_n = 1;
        model_reset();
        cycle(1, 8'hA5, 8'h5A, 2'b00, 0);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL preload_a5: got %h exp a5", q); end
        cycle(1, 8'h01, 8'h01, 2'b00, 0);
        @(negedge clk);
        en = 0; #2;
        rst_n = 0; #1;
        model_reset();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL async_reset_q: got %h exp 00", q); end
        checks++; if (qb !== 8'hFF) begin errors++; $display("FAIL async_reset_qb: got %h exp ff", qb); end
        checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL async_reset_conflict: got %b exp 0", conflict); end
        checks++; if (conflict_cnt !== '0) begin errors++; $display("FAIL async_reset_cnt: got %0d exp 0", conflict_cnt); end
        @(negedge clk) rst_n = 1;
    endtask

    task automatic test_basic();
        cycle(1, 8'h0F, 8'h00, 2'b00, 0);
        checks++; if (q !== 8'h0F) begin errors++; $display("FAIL basic_set: got %h exp 0f", q); end
        cycle(1, 8'h00, 8'h03, 2'b00, 0);
        checks++; if (q !== 8'h0C) begin errors++; $display("FAIL basic_reset: got %h exp 0c", q); end
        for (int k = 0; k < 3; k++) begin
            cycle(1, 8'h00, 8'h00, 2'b00, 0);
            checks++; if (q !== 8'h0C || qb !== 8'hF3) begin errors++; $display("FAIL basic_hold: got q=%h qb=%h exp 0c/f3", q, qb); end
        end
    endtask

    task automatic test_modes();
        logic [W-1:0] exp_q [4];
        exp_q[0] = 8'h0C; exp_q[1] = 8'h0D; exp_q[2] = 8'h08; exp_q[3] = 8'h09;
        for (int m = 0; m < 4; m++) begin
            cycle(1, 8'h0C, 8'hF3, 2'b00, 0);
            cycle(1, 8'h05, 8'h05, 2'(m), 0);
            checks++; if (q !== exp_q[m]) begin errors++; $display("FAIL mode%0d_q: got %h exp %h", m, q, exp_q[m]); end
            checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL mode%0d_conflict: got %b exp 1", m, conflict); end
            checks++; if (conflict_cnt !== CW'(cnt_m)) begin errors++; $display("FAIL mode%0d_cnt: got %0d exp %0d", m, conflict_cnt, cnt_m); end
            cycle(1, 8'h00, 8'h00, 2'(m), 0);
            checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL mode%0d_conflict_drop: got %b exp 0", m, conflict); end
        end
    endtask

    task automatic test_toggle();
        cycle(1, 8'h00, 8'hFF, 2'b00, 1);
        for (int k = 1; k <= 4; k++) begin
            cycle(1, 8'h01, 8'h01, 2'b11, 0);
            checks++; if (q !== 8'(k % 2)) begin errors++; $display("FAIL toggle_q%0d: got %h exp %h", k, q, 8'(k % 2)); end
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
            checks++; if (conflict_cnt !== CW'(k)) begin errors++; $display("FAIL toggle_cnt%0d: got %0d exp %0d", k, conflict_cnt, k); end
`else
            checks++; if (conflict_cnt !== '0) begin errors++; $display("FAIL toggle_cnt%0d: got %0d exp 0", k, conflict_cnt); end
`endif
        end
    endtask

    task automatic test_enable();
        logic [W-1:0] q0;
        logic [CW-1:0] c0;
        cycle(1, 8'h3C, 8'hC3, 2'b00, 0);
        q0 = q_m; c0 = CW'(cnt_m);
        for (int m = 0; m < 4; m++) begin
            cycle(0, 8'hFF, 8'hFF, 2'(m), 0);
            checks++; if (q !== q0 || conflict !== 1'b0 || conflict_cnt !== c0)
                begin errors++; $display("FAIL enable_gate%0d: got q=%h c=%b n=%0d exp q=%h c=0 n=%0d", m, q, conflict, conflict_cnt, q0, c0); end
        end
    endtask

    task automatic test_counter();
        cycle(1, 8'h00, 8'h00, 2'b00, 1);
        for (int k = 0; k < 20; k++) cycle(1, 8'hFF, 8'hFF, 2'(k), 0);
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
        checks++; if (conflict_cnt !== 4'd15) begin errors++; $display("FAIL cnt_saturate: got %0d exp 15", conflict_cnt); end
`else
        checks++; if (conflict_cnt !== 4'd0) begin errors++; $display("FAIL cnt_disabled: got %0d exp 0", conflict_cnt); end
`endif
        checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL cnt_sat_conflict: got %b exp 1", conflict); end
        cycle(1, 8'h80, 8'h80, 2'b01, 1);
        checks++; if (conflict_cnt !== 4'd0 || conflict !== 1'b1)
            begin errors++; $display("FAIL cnt_clear_wins: got n=%0d c=%b exp n=0 c=1", conflict_cnt, conflict); end
        cycle(1, 8'h80, 8'h80, 2'b01, 0);
        checks++; if (conflict_cnt !== CW'(cnt_m)) begin errors++; $display("FAIL cnt_after_clear: got %0d exp %0d", conflict_cnt, cnt_m); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 7) != 0), W'($urandom), W'($urandom), 2'($urandom), ($urandom_range(0, 15) == 0));
            checks++; if (q !== q_m || qb !== ~q_m || conflict !== conf_m || conflict_cnt !== CW'(cnt_m))
                begin errors++; $display("FAIL random%0d: got q=%h qb=%h c=%b n=%0d exp q=%h c=%b n=%0d", k, q, qb, conflict, conflict_cnt, q_m, conf_m, cnt_m); end
            if ($urandom_range(0, 49) == 0) begin
                #2;
                en = 0; clr_cnt = 0; rst_n = 0; #1;
                model_reset();
                checks++; if (q !== '0 || qb !== '1 || conflict !== 1'b0 || conflict_cnt !== '0)
                    begin errors++; $display("FAIL random_reset%0d: got q=%h qb=%h c=%b n=%0d exp 00/ff/0/0", k, q, qb, conflict, conflict_cnt); end
                @(negedge clk) rst_n = 1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_toggle();
        test_enable();
        test_counter();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
